// File: rtl/fp8_pkg.sv
// Shared FP8 (S|EEE|MMMM, hidden leading one) types and constants.
package fp8_pkg;

    localparam int FP8_EXP_W = 3;
    localparam int FP8_MAN_W = 4;
    localparam int FP8_BIAS  = 3;

    typedef struct packed {
        logic                 sign;
        logic [FP8_EXP_W-1:0] exp;
        logic [FP8_MAN_W-1:0] man;
    } fp8_t;

    // A value is treated as zero when both exponent and mantissa fields are clear.
    function automatic logic fp8_is_zero(input fp8_t v);
        return (v.exp == 3'd0) && (v.man == 4'd0);
    endfunction

endpackage

// File: rtl/fp8_mult_round.sv
// Combinational FP8 product finishing: round, remove bias, pack, flag.
// Rounding is built only when FP8_MULT_ROUND_EN is defined; otherwise truncates.
module fp8_mult_round
    import fp8_pkg::*;
#(
    parameter int         BIAS       = FP8_BIAS,
    parameter logic [7:0] SAT_RESULT = 8'h7F
) (
    input  logic       sign_i,
    input  logic [3:0] norm_man_i,
    input  logic [3:0] norm_exp_i,
`ifdef FP8_MULT_ROUND_EN
    input  logic       grs_i,
`endif
    input  logic       zero_i,
    output fp8_t       result_o,
    output logic       ovf_o,
    output logic       unf_o
);

    logic [3:0] man_rnd_s;
    logic [4:0] exp_adj_s;
    logic [4:0] exp_unb_s;

`ifdef FP8_MULT_ROUND_EN
    logic [4:0] man_sum_s;

    // Round up on sticky/guard, a mantissa carry-out bumps the exponent.
    always_comb begin
        man_sum_s = {1'b0, norm_man_i} + {4'd0, grs_i};
        if (man_sum_s[4]) begin
            man_rnd_s = 4'd0;
            exp_adj_s = {1'b0, norm_exp_i} + 5'd1;
        end else begin
            man_rnd_s = man_sum_s[3:0];
            exp_adj_s = {1'b0, norm_exp_i};
        end
    end
`else
    // Truncation: normalized mantissa and exponent pass straight through.
    always_comb begin
        man_rnd_s = norm_man_i;
        exp_adj_s = {1'b0, norm_exp_i};
    end
`endif

    // Remove the bias and choose between zero, flush, saturate and normal pack.
    always_comb begin
        exp_unb_s = exp_adj_s - 5'(BIAS);
        result_o  = {sign_i, 7'd0};
        ovf_o     = 1'b0;
        unf_o     = 1'b0;
        if (zero_i) begin
            result_o = {sign_i, 7'd0};
        end else if (exp_adj_s < 5'(BIAS)) begin
            result_o = {sign_i, 7'd0};
            unf_o    = 1'b1;
        end else if (exp_unb_s > 5'd7) begin
            result_o = {sign_i, SAT_RESULT[6:0]};
            ovf_o    = 1'b1;
        end else begin
            result_o = {sign_i, exp_unb_s[2:0], man_rnd_s};
        end
    end

endmodule

// File: rtl/fp8_mult_scheduler.sv
// Two-requester round-robin front end for a shared two-stage FP8 multiplier
// with a single tagged, backpressured result port.
// Optional rounding is enabled by defining FP8_MULT_ROUND_EN.
module fp8_mult_scheduler
    import fp8_pkg::*;
#(
    parameter int         BIAS       = FP8_BIAS,
    parameter logic [7:0] SAT_RESULT = 8'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_tag,
    output logic       out_ovf,
    output logic       out_unf
);

    logic       advance_s, gnt0_s, gnt1_s, xfer_s;
    logic       last_gnt_q, last_gnt_d;
    fp8_t       op_a_s, op_b_s;
    logic [9:0] mp_s;
    logic [3:0] norm_man_s, norm_exp_s;
    logic       zero_s;

    logic       s1_valid_q, s1_sign_q, s1_zero_q, s1_tag_q;
    logic [3:0] s1_man_q, s1_exp_q;

    logic       out_valid_q, out_tag_q, out_ovf_q, out_unf_q;
    logic [7:0] out_result_q;
    fp8_t       rnd_result_s;
    logic       rnd_ovf_s, rnd_unf_s;

    assign advance_s = !out_valid_q || out_ready;

    // Grant selection; last_gnt_q = 1 means requester 1 won the last transfer.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0_s = last_gnt_q;
            gnt1_s = !last_gnt_q;
        end else if (req0_valid) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = advance_s && gnt0_s;
    assign req1_ready = advance_s && gnt1_s;
    assign xfer_s     = req0_ready || req1_ready;
    assign last_gnt_d = xfer_s ? gnt1_s : last_gnt_q;

    // Stage-1 datapath: mantissa product, normalization and zero detect.
    always_comb begin
        op_a_s     = gnt1_s ? fp8_t'(req1_a) : fp8_t'(req0_a);
        op_b_s     = gnt1_s ? fp8_t'(req1_b) : fp8_t'(req0_b);
        mp_s       = {5'd0, 1'b1, op_a_s.man} * {5'd0, 1'b1, op_b_s.man};
        norm_man_s = mp_s[9] ? mp_s[8:5] : mp_s[7:4];
        norm_exp_s = {1'b0, op_a_s.exp} + {1'b0, op_b_s.exp} + {3'd0, mp_s[9]};
        zero_s     = fp8_is_zero(op_a_s) || fp8_is_zero(op_b_s);
    end

`ifdef FP8_MULT_ROUND_EN
    logic s1_grs_q;

    // Guard/round/sticky capture, only needed when rounding is built.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_grs_q <= 1'b0;
        end else if (advance_s) begin
            s1_grs_q <= (mp_s[4] & mp_s[3]) | (|mp_s[2:0]);
        end
    end
`else
    // Low product bits only feed rounding, which this build leaves out.
    logic unused_low_s;
    assign unused_low_s = ^mp_s[3:0];
`endif

    // Stage-1 register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_tag_q   <= 1'b0;
            s1_man_q   <= 4'd0;
            s1_exp_q   <= 4'd0;
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
            if (advance_s) begin
                s1_valid_q <= xfer_s;
                s1_sign_q  <= op_a_s.sign ^ op_b_s.sign;
                s1_zero_q  <= zero_s;
                s1_tag_q   <= gnt1_s;
                s1_man_q   <= norm_man_s;
                s1_exp_q   <= norm_exp_s;
            end
        end
    end

    fp8_mult_round #(
        .BIAS       (BIAS),
        .SAT_RESULT (SAT_RESULT)
    ) u_round (
        .sign_i     (s1_sign_q),
        .norm_man_i (s1_man_q),
        .norm_exp_i (s1_exp_q),
`ifdef FP8_MULT_ROUND_EN
        .grs_i      (s1_grs_q),
`endif
        .zero_i     (s1_zero_q),
        .result_o   (rnd_result_s),
        .ovf_o      (rnd_ovf_s),
        .unf_o      (rnd_unf_s)
    );

    // Stage-2 / output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 8'd0;
            out_tag_q    <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
        end else if (advance_s) begin
            out_valid_q  <= s1_valid_q;
            out_result_q <= rnd_result_s;
            out_tag_q    <= s1_tag_q;
            out_ovf_q    <= rnd_ovf_s;
            out_unf_q    <= rnd_unf_s;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_ovf    = out_ovf_q;
    assign out_unf    = out_unf_q;

endmodule

// File: tb/tb_fp8_mult_scheduler.sv
// Self-checking bench for fp8_mult_scheduler: directed cases plus randomized
// traffic against an arithmetic reference and a two-slot pipeline model.
module tb_fp8_mult_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       out_valid, out_ready, out_tag, out_ovf, out_unf;
    logic [7:0] out_result;

    always #5 clk = ~clk;

    fp8_mult_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product from the format rules: returns {ovf, unf, result}.
    function automatic logic [9:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int  ea, eb, p, sh, e, m;
        bit  s;
        s = a[7] ^ b[7];
        if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return {2'b00, s, 7'd0};
        ea = int'(a[6:4]);
        eb = int'(b[6:4]);
        p  = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        sh = (p >= 512) ? 5 : 4;
        e  = ea + eb + (sh - 4);
        m  = (p >> sh) % 16;
`ifdef FP8_MULT_ROUND_EN
        if ((((p >> 3) % 4) == 3) || ((p % 8) != 0)) m = m + 1;
        if (m == 16) begin
            m = 0;
            e = e + 1;
        end
`endif
        if (e < 3) return {2'b01, s, 7'd0};
        if (e - 3 > 7) return {2'b10, s, 7'h7F};
        return {2'b00, s, 3'(e - 3), 4'(m)};
    endfunction

    typedef struct {
        bit         v;
        logic [7:0] res;
        bit         tag;
        bit         ovf;
        bit         unf;
    } item_t;

    item_t m_s1, m_s2;
    bit    m_last1;
    bit    m_known = 1'b0;
    bit    acc0, acc1;

    // One clock: drive inputs, check at negedge, advance the model at posedge.
    task automatic step(input bit r, input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                        input bit v1, input logic [7:0] a1, input logic [7:0] b1, input bit ordy);
        bit          adv, g0, g1, e0, e1;
        logic [9:0]  rm;
        rst = r; req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1; out_ready = ordy;
        @(negedge clk);
        adv = !m_s2.v || ordy;
        g0 = 1'b0; g1 = 1'b0;
        if (v0 && v1) begin
            g0 = m_last1;
            g1 = !m_last1;
        end else begin
            g0 = v0;
            g1 = v1;
        end
        e0 = adv && g0;
        e1 = adv && g1;
        acc0 = e0;
        acc1 = e1;
        if (m_known) begin
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            check("out_valid", out_valid, m_s2.v);
            if (m_s2.v) begin
                check("out_result", out_result, m_s2.res);
                check("out_tag", out_tag, m_s2.tag);
                check("out_ovf", out_ovf, m_s2.ovf);
                check("out_unf", out_unf, m_s2.unf);
            end
        end
        @(posedge clk);
        if (r) begin
            m_s1.v = 1'b0;
            m_s2.v = 1'b0;
            m_last1 = 1'b1;
            m_known = 1'b1;
        end else if (adv) begin
            m_s2 = m_s1;
            m_s1.v = e0 || e1;
            if (e0 || e1) begin
                rm = e1 ? ref_mul(a1, b1) : ref_mul(a0, b0);
                m_s1.res = rm[7:0];
                m_s1.unf = rm[8];
                m_s1.ovf = rm[9];
                m_s1.tag = e1;
                m_last1 = e1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    // Directed expectation on the current output registers.
    task automatic expect_out(input string tag, input logic [7:0] res, input bit tg, input bit ovf, input bit unf);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_result"}, out_result, res);
        check({tag, "_tag"}, out_tag, tg);
        check({tag, "_ovf"}, out_ovf, ovf);
        check({tag, "_unf"}, out_unf, unf);
    endtask

    initial begin
        logic [7:0] a0, b0, a1, b1;
        bit         v0, v1;
        m_s1 = '{default: 0};
        m_s2 = '{default: 0};
        m_last1 = 1'b1;
        acc0 = 1'b0;
        acc1 = 1'b0;
        #1;
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_result", out_result, 8'h00);
        check("rst_tag", out_tag, 1'b0);
        check("rst_ovf", out_ovf, 1'b0);
        check("rst_unf", out_unf, 1'b0);

        // 1.0 * 3.0 = 3.0
        step(1'b0, 1'b1, 8'h30, 8'h48, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(1);
        expect_out("basic", 8'h48, 1'b0, 1'b0, 1'b0);
        idle(1);

        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h31, 8'h31, 1'b1);
        idle(1);
`ifdef FP8_MULT_ROUND_EN
        expect_out("round", 8'h33, 1'b1, 1'b0, 1'b0);
`else
        expect_out("round", 8'h32, 1'b1, 1'b0, 1'b0);
`endif
        idle(1);

        step(1'b0, 1'b1, 8'h7F, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b1);
        idle(1);
        expect_out("ovf", 8'h7F, 1'b0, 1'b1, 1'b0);
        idle(1);

        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h90, 8'h10, 1'b1);
        idle(1);
        expect_out("unf", 8'h80, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Contention: requester 1 won last, so grants run 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h38 + 8'(i), 8'h41, 1'b1, 8'hB2, 8'h29 + 8'(i), 1'b1);
            check("arb_grant0", acc0, (i % 2 == 0));
        end
        idle(3);

        // Fill the pipe, stall three cycles, then release.
        step(1'b0, 1'b1, 8'h35, 8'h44, 1'b1, 8'h46, 8'h23, 1'b0);
        step(1'b0, 1'b1, 8'h35, 8'h44, 1'b1, 8'h46, 8'h23, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h52, 8'h2C, 1'b1, 8'h46, 8'h23, 1'b0);
            check("bp_ready0", req0_ready, 1'b0);
        end
        idle(4);

        // Reset with two operations in flight.
        step(1'b0, 1'b1, 8'h33, 8'h34, 1'b1, 8'h45, 8'h56, 1'b1);
        step(1'b0, 1'b1, 8'h33, 8'h34, 1'b1, 8'h45, 8'h56, 1'b1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        check("rst_flush_valid", out_valid, 1'b0);
        step(1'b0, 1'b1, 8'h3A, 8'h3B, 1'b1, 8'h4C, 8'h4D, 1'b1);
        check("rst_first_grant0", acc0, 1'b1);
        idle(3);

        // Randomized traffic; a pending request holds its operands.
        v0 = 1'b0; v1 = 1'b0;
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            if (!(v0 && !acc0)) begin
                v0 = ($urandom % 3) != 0;
                a0 = 8'($urandom);
                b0 = 8'($urandom);
                if ($urandom % 10 == 0) a0[6:0] = 7'd0;
            end
            if (!(v1 && !acc1)) begin
                v1 = ($urandom % 3) != 0;
                a1 = 8'($urandom);
                b1 = 8'($urandom);
                if ($urandom % 10 == 0) b1[6:0] = 7'd0;
            end
            r = ($urandom % 300) == 0;
            step(r, v0, a0, b0, v1, a1, b1, ($urandom % 4) != 0);
            if (r) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp8_mult_scheduler.md
Name: fp8_mult_scheduler

Overview:
- Shares one FP8 multiply datapath (format S|EEE|MMMM, hidden leading 1, bias 3) between two requesters.
- Round-robin arbiter accepts operand pairs over valid/ready handshakes.
- Two-stage pipeline: stage 1 = multiply/normalize, stage 2 = round/bias/pack.
- Single tagged result port with backpressure; sits between issuing units and the writeback bus.

Parameters:
BIAS, 3, exponent bias subtracted from summed exponents
SAT_RESULT, 8'h7F, magnitude (bits 6:0 used) returned on exponent overflow

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 operands valid
req0_ready  out  1  requester 0 accepted this cycle (valid&ready = transfer)
req0_a  in  8  operand A, requester 0
req0_b  in  8  operand B, requester 0
req1_valid  in  1  requester 1 operands valid
req1_ready  out  1  requester 1 accepted
req1_a  in  8  operand A, requester 1
req1_b  in  8  operand B, requester 1
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  8  packed product
out_tag  out  1  originating requester index
out_ovf  out  1  exponent overflow, result saturated
out_unf  out  1  exponent underflow, result flushed to signed zero

Behaviour:
- Reset is synchronous and active-high on clk: rst high at a clk edge clears s1_valid, s2_valid and out_valid. It sets the round-robin pointer to favour requester 0. out_result, out_tag, out_ovf and out_unf reset to 0.
- advance = !s2_valid || out_ready. Stage 1 loads when advance is high. Stage 2 loads when advance is high; s2_valid <= s1_valid.
- reqN_ready is combinational: high only if advance is high and N is the grantee.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not granted last.
  - The pointer updates only on an actual transfer.
- Stage 1 register captures:
  - Sp = a[7]^b[7]
  - Mp = {1,a[3:0]}*{1,b[3:0]} (10 bits)
  - NormM = Mp[9] ? Mp[8:5] : Mp[7:4]
  - NormE = a[6:4]+b[6:4]+Mp[9] (4 bits, unsigned)
  - GRS = (Mp[4]&Mp[3]) | |Mp[2:0]
  - zero flag = (a[6:0]==0)||(b[6:0]==0)
  - tag
- Stage 2, rounding:
  - M' = NormM + GRS (with ROUND_EN), else NormM.
  - If M' carries out of 4 bits: M' = 0, E' = NormE+1 (5-bit arithmetic).
- Stage 2, exponent and result:
  - Zero flag set: result {Sp,7'b0}, no flags.
  - E' < BIAS: result {Sp,7'b0}, out_unf=1.
  - E'-BIAS > 7: result {Sp,SAT_RESULT[6:0]}, out_ovf=1.
  - Otherwise: result {Sp,(E'-BIAS)[2:0],M'}.
- Latency: transfer at edge k → out_valid at edge k+2 when no stall. Throughput is 1 per cycle.
- Stall with out_ready low and s2_valid high:
  - Outputs hold stable.
  - Stage 1 holds.
  - Both reqN_ready go low.
- Result ordering is strictly acceptance order. Nothing is dropped and nothing is duplicated.
- Reset mid-operation discards all in-flight results. No output pulse follows reset.

Optional Feature:
- Macro: FP8_MULT_ROUND_EN.
- Defined: GRS increments the mantissa, with carry into the exponent.
- Undefined: truncation. GRS is ignored and the stage-1 GRS register is not built.

Decomposition:
- Shared package fp8_pkg holds:
  - typedef fp8_t, a packed struct {sign, exp[2:0], man[3:0]}
  - FP8_BIAS
  - FP8_EXP_W = 3
  - FP8_MAN_W = 4
- One sub-module, fp8_mult_round: combinational stage-2 round/bias/pack/flags logic, reused by future FP8 units.
- The arbiter and pipeline registers stay in the top module.

Test Plan:
- Basic product: req0 a=8'h30, b=8'h48 → 2 cycles later out_result=8'h48, tag=0, ovf=0, unf=0 (1.0*3.0=3.0).
- Rounding: req1 a=8'h31, b=8'h31 → 8'h33 with FP8_MULT_ROUND_EN; 8'h32 without; tag=1.
- Overflow and underflow:
  - a=b=8'h7F → out_result=8'h7F, ovf=1.
  - a=8'h90, b=8'h10 (NormE=2) → out_result=8'h80, unf=1.
- Arbitration: both requesters valid for 4 consecutive cycles, out_ready=1 → grants alternate 0,1,0,1; results arrive in the same tag order.
- Backpressure: out_ready=0 for 3 cycles with the pipe full → out_result stable, both readys 0. Release → each queued result appears once, in order.
- Reset: rst asserted while 2 ops are in flight → out_valid=0 the next cycle. First post-reset contention grants requester 0.
